// File: rtl/counter_pkg.sv
// Shared definitions for the loadable down counter: state encodings and default width.
package counter_pkg;

    // Default counter / load-value width in bits.
    localparam int unsigned DefaultWidth = 4;

    // Control state encodings; the values are fixed so that other blocks can decode them.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/dffe.sv
// Single-bit register with asynchronous active-low reset and a synchronous enable.
module dffe (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic d,
    output logic q
);

    // Capture d on enabled rising edges; clear immediately on reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a registered terminal-count pulse.
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_en;
    logic [WIDTH-1:0] rld_q;
    logic             rld_en;
    logic             tc_q, tc_d;
    logic             count_step;
    logic             at_one;

    // An enabled count cycle in RUN that is not overridden by a load.
    assign count_step = (state_q == StRun) && en && !load;
    assign at_one     = (q_q == WIDTH'(1));

    // Count and reload-value banks, one dffe per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        dffe u_q (
            .clk  (clk),
            .rstb (rstb),
            .en   (q_en),
            .d    (q_d[i]),
            .q    (q_q[i])
        );
        dffe u_rld (
            .clk  (clk),
            .rstb (rstb),
            .en   (rld_en),
            .d    (load_val[i]),
            .q    (rld_q[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load wins everywhere; only a one-shot terminal step leaves RUN for DONE.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val != '0) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StRun:   if (en && at_one && !reload) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Count datapath: load, decrement, or terminal (clear or reload).
    always_comb begin
        q_d    = q_q;
        q_en   = 1'b0;
        rld_en = load;
        tc_d   = 1'b0;
        if (load) begin
            q_d  = load_val;
            q_en = 1'b1;
        end else if (count_step) begin
            q_en = 1'b1;
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else if (at_one) begin
                tc_d = 1'b1;
                q_d  = reload ? rld_q : '0;
            end else begin
                // Q == 0 cannot occur in RUN; hold rather than wrap.
                q_d = q_q;
            end
        end
    end

    // Terminal-count pulse register; cleared on every non-terminal cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: behavioural model compared every cycle plus literal checks.
module tb_down_counter;

    localparam int W = 4;

    logic         clk;
    logic         rstb;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         reload;
    logic [W-1:0] Q;
    logic         tc;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .reload   (reload),
        .Q        (Q),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: mode 0 = idle, 1 = counting, 2 = finished.
    int m_count = 0;
    int m_start = 0;
    int m_mode  = 0;
    int m_tc    = 0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_count = 0;
            m_start = 0;
            m_mode  = 0;
            m_tc    = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_start = int'(load_val);
                m_count = m_start;
                m_mode  = (m_start == 0) ? 0 : 1;
            end else if (m_mode == 1 && en) begin
                if (m_count == 1) begin
                    m_tc = 1;
                    if (reload) begin
                        m_count = m_start;
                    end else begin
                        m_count = 0;
                        m_mode  = 2;
                    end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("model_Q", int'(Q), m_count);
        chk("model_tc", int'(tc), m_tc);
        chk("model_busy", int'(busy), int'(m_mode == 1));
        chk("model_done", int'(done), int'(m_mode == 2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_q[];
    int exp_tc[];
    int en_pat[];

    initial begin
        rstb     = 1'b1;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        reload   = 1'b0;
        #1 rstb  = 1'b0;
        tick();
        tick();
        chk("reset_Q", int'(Q), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rstb = 1'b1;

        // One-shot from 5 with en held (load wins over en on the first edge).
        load = 1'b1; load_val = 4'd5; en = 1'b1; reload = 1'b0;
        tick();
        chk("os_load_Q", int'(Q), 5);
        chk("os_load_busy", int'(busy), 1);
        load = 1'b0;
        exp_q = '{4, 3, 2, 1, 0};
        foreach (exp_q[i]) begin
            tick();
            chk("os_Q", int'(Q), exp_q[i]);
            chk("os_tc", int'(tc), int'(exp_q[i] == 0));
        end
        chk("os_done", int'(done), 1);
        tick();
        tick();
        chk("os_hold_Q", int'(Q), 0);
        chk("os_hold_tc", int'(tc), 0);
        chk("os_hold_done", int'(done), 1);

        // Auto-reload from 3.
        load = 1'b1; load_val = 4'd3; reload = 1'b1; en = 1'b1;
        tick();
        chk("rl_load_Q", int'(Q), 3);
        load = 1'b0;
        exp_q  = '{2, 1, 3, 2, 1, 3, 2, 1};
        exp_tc = '{0, 0, 1, 0, 0, 1, 0, 0};
        foreach (exp_q[i]) begin
            tick();
            chk("rl_Q", int'(Q), exp_q[i]);
            chk("rl_tc", int'(tc), exp_tc[i]);
            chk("rl_busy", int'(busy), 1);
        end

        // Reload value 1: terminal event on every enabled cycle.
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rl1_Q", int'(Q), 1);
            chk("rl1_tc", int'(tc), 1);
        end

        // Gated one-shot from 4.
        load = 1'b1; load_val = 4'd4; reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        en_pat = '{1, 0, 1, 0, 1, 0, 1};
        exp_q  = '{3, 3, 2, 2, 1, 1, 0};
        foreach (en_pat[i]) begin
            en = en_pat[i][0];
            tick();
            chk("gate_Q", int'(Q), exp_q[i]);
        end
        chk("gate_tc", int'(tc), 1);
        chk("gate_done", int'(done), 1);
        en = 1'b0;
        tick();
        chk("gate_done_hold", int'(done), 1);

        // Load collides with the terminal step: restart at 9, no pulse.
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        chk("coll_pre_Q", int'(Q), 1);
        load = 1'b1; load_val = 4'd9;
        tick();
        chk("coll_Q", int'(Q), 9);
        chk("coll_tc", int'(tc), 0);
        chk("coll_busy", int'(busy), 1);
        load = 1'b0;

        // Asynchronous reset at Q=2, then a zero load.
        for (int i = 0; i < 7; i++) tick();
        chk("ar_pre_Q", int'(Q), 2);
        #2 rstb = 1'b0;
        #1;
        chk("ar_Q", int'(Q), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_tc", int'(tc), 0);
        tick();
        chk("ar_held_Q", int'(Q), 0);
        rstb = 1'b1;
        load = 1'b1; load_val = 4'd0;
        tick();
        chk("z_Q", int'(Q), 0);
        chk("z_busy", int'(busy), 0);
        chk("z_done", int'(done), 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("z_tc", int'(tc), 0);
            chk("z_idle_Q", int'(Q), 0);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
